// File: rtl/textlcd_pkg.sv
// Shared constants, state encoding and DDRAM row-base lookup for the text-LCD controller.
package textlcd_pkg;

    // HD44780 command bytes
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_DISP_CUR = 8'h0F;  // display on, cursor + blink
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment address, no shift
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_DDRAM    = 8'h80;  // set-DDRAM-address opcode bit

    localparam logic [7:0] ASCII_BLANK  = 8'h20;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHARS,
        ST_CURSOR
    } state_e;

    // DDRAM start address of each display row (1/2/4-row glass).
    function automatic logic [6:0] row_base(input int r);
        case (r)
            0:       return 7'h00;
            1:       return 7'h40;
            2:       return 7'h14;
            default: return 7'h54;
        endcase
    endfunction

endpackage

// File: rtl/textlcd_tick.sv
// Prescaler: one-clk tick pulse every TICK_DIV clk cycles; paces the LCD bus.
module textlcd_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Count up and wrap on the tick cycle.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            // NOTE: flops take non-blocking (<=) so every register samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/textlcd_ctrl.sv
// HD44780-class character-LCD controller: power-up init, then full-screen rewrites from
// a latched shadow frame. Each byte takes three ticks (set-up, E high, E low/hold).
// Optional feature: define TEXTLCD_CURSOR_EN to add cursor_on/cursor_pos inputs, a
// cursor+blink display-on command and a trailing cursor-placement command per refresh.
module textlcd_ctrl
    import textlcd_pkg::*;
#(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int TICK_DIV    = 50000,
    parameter int PWRUP_TICKS = 70,
    parameter int CLEAR_TICKS = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [ROWS*COLS*8-1:0]   frame_data,
    input  logic                     frame_valid,
`ifdef TEXTLCD_CURSOR_EN
    input  logic                     cursor_on,
    input  logic [$clog2(ROWS*COLS)-1:0] cursor_pos,
`endif
    output logic                     frame_ready,
    output logic                     busy,
    output logic                     LCD_E,
    output logic                     LCD_RS,
    output logic                     LCD_RW,
    output logic [7:0]               LCD_DATA
);

    localparam int NCHARS   = ROWS * COLS;
    localparam int FRAME_W  = NCHARS * 8;
    localparam int COL_W    = $clog2(COLS + 1);
    localparam int ROW_W    = $clog2(ROWS + 1);
    localparam int SEL_W    = $clog2(FRAME_W);
    localparam int WAIT_MAX = (PWRUP_TICKS > CLEAR_TICKS) ? PWRUP_TICKS : CLEAR_TICKS;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    state_e               state_q, state_d;
    logic [1:0]           phase_q, phase_d;   // 0: set-up, 1: E high, 2: E low/hold
    logic [2:0]           idx_q, idx_d;       // init command index; 4 = clear wait
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 pending_q, pending_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic                 e_q, e_d, rs_q, rs_d;
    logic [7:0]           data_q, data_d;

    logic                 tick, sending, byte_done, rs_sel;
    logic [7:0]           byte_sel, disp_on_cmd;
    logic [SEL_W-1:0]     sel_lo;
    state_e               end_state;

    textlcd_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick)
    );

`ifdef TEXTLCD_CURSOR_EN
    logic                          cur_on_q, cur_on_d;
    logic [$clog2(ROWS*COLS)-1:0]  cur_pos_q, cur_pos_d;
    logic [6:0]                    cur_addr;
    logic                          cur_valid;

    // Cursor DDRAM address and validity from the values sampled with the frame.
    always_comb begin
        cur_addr  = row_base(int'(cur_pos_q) / COLS) + 7'(int'(cur_pos_q) % COLS);
        cur_valid = cur_on_q && (int'(cur_pos_q) < NCHARS);
        end_state = cur_valid ? ST_CURSOR : ST_IDLE;
        disp_on_cmd = cursor_on ? LCD_DISP_CUR : LCD_DISP_ON;
    end
`else
    assign end_state   = ST_IDLE;
    assign disp_on_cmd = LCD_DISP_ON;
`endif

    assign frame_ready = (state_q == ST_IDLE) && !pending_q;
    assign busy        = (state_q != ST_IDLE);
    assign LCD_E       = e_q;
    assign LCD_RS      = rs_q;
    assign LCD_RW      = 1'b0;
    assign LCD_DATA    = data_q;

    assign sending = (state_q == ST_ADDR) || (state_q == ST_CHARS) || (state_q == ST_CURSOR) ||
                     ((state_q == ST_INIT) && (idx_q != 3'd4));

    // Select the byte and RS level the current state puts on the bus at its next set-up tick.
    always_comb begin
        sel_lo   = SEL_W'((NCHARS - 1 - (int'(row_q) * COLS + int'(col_q))) * 8);
        byte_sel = 8'h00;
        rs_sel   = 1'b0;
        case (state_q)
            ST_INIT: begin
                case (idx_q)
                    3'd0:    byte_sel = LCD_FUNC_SET;
                    3'd1:    byte_sel = disp_on_cmd;
                    3'd2:    byte_sel = LCD_ENTRY;
                    default: byte_sel = LCD_CLEAR;
                endcase
            end
            ST_ADDR:  byte_sel = LCD_DDRAM | {1'b0, row_base(int'(row_q))};
            ST_CHARS: begin
                byte_sel = shadow_q[sel_lo +: 8];
                rs_sel   = 1'b1;
            end
`ifdef TEXTLCD_CURSOR_EN
            ST_CURSOR: byte_sel = LCD_DDRAM | {1'b0, cur_addr};
`endif
            default: ;
        endcase
    end

    // Next-state logic: frame handshake every clk, FSM and bus sequencing on ticks only.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        row_d     = row_q;
        col_d     = col_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        e_d       = e_q;
        rs_d      = rs_q;
        data_d    = data_q;
        byte_done = 1'b0;
`ifdef TEXTLCD_CURSOR_EN
        cur_on_d  = cur_on_q;
        cur_pos_d = cur_pos_q;
`endif

        if (frame_valid && frame_ready) begin
            shadow_d  = frame_data;
            pending_d = 1'b1;
`ifdef TEXTLCD_CURSOR_EN
            cur_on_d  = cursor_on;
            cur_pos_d = cursor_pos;
`endif
        end

        if (tick) begin
            if (sending) begin
                case (phase_q)
                    2'd0: begin
                        rs_d    = rs_sel;
                        data_d  = byte_sel;
                        e_d     = 1'b0;
                        phase_d = 2'd1;
                    end
                    2'd1: begin
                        e_d     = 1'b1;
                        phase_d = 2'd2;
                    end
                    default: begin
                        e_d       = 1'b0;
                        phase_d   = 2'd0;
                        byte_done = 1'b1;
                    end
                endcase
            end

            case (state_q)
                ST_PWRUP: begin
                    if (wait_q == WAIT_W'(PWRUP_TICKS - 1)) begin
                        state_d = ST_INIT;
                        idx_d   = 3'd0;
                        wait_d  = '0;
                        phase_d = 2'd0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ST_INIT: begin
                    if (idx_q == 3'd4) begin
                        if (wait_q == WAIT_W'(CLEAR_TICKS - 1)) begin
                            state_d = ST_IDLE;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end else if (byte_done) begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                ST_IDLE: begin
                    if (pending_q) begin
                        state_d   = ST_ADDR;
                        row_d     = '0;
                        col_d     = '0;
                        phase_d   = 2'd0;
                        pending_d = 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (byte_done) state_d = ST_CHARS;
                end
                ST_CHARS: begin
                    if (byte_done) begin
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d = '0;
                            if (row_q == ROW_W'(ROWS - 1)) begin
                                row_d   = '0;
                                state_d = end_state;
                            end else begin
                                row_d   = row_q + 1'b1;
                                state_d = ST_ADDR;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                ST_CURSOR: begin
                    if (byte_done) state_d = ST_IDLE;
                end
                default: state_d = ST_PWRUP;
            endcase
        end
    end

    // State, counters, shadow frame and bus registers; reset drops E at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_PWRUP;
            phase_q   <= 2'd0;
            idx_q     <= 3'd0;
            wait_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pending_q <= 1'b0;
            // NOTE: the shadow frame is a flop register, not a RAM, so it can and does take a reset value.
            shadow_q  <= {NCHARS{ASCII_BLANK}};
            e_q       <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
`ifdef TEXTLCD_CURSOR_EN
            cur_on_q  <= 1'b0;
            cur_pos_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            e_q       <= e_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
`ifdef TEXTLCD_CURSOR_EN
            cur_on_q  <= cur_on_d;
            cur_pos_q <= cur_pos_d;
`endif
        end
    end

endmodule
